// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ASR  = 3'd5;
    localparam logic [2:0] MODE_LOAD = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Only shift/rotate modes are worth repeating in a burst.
    function automatic logic is_shift(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational next-value logic for one register step; shared by single-step and burst paths.
module shift_core
    import univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pdata,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] nxt,
    output logic             ej_l,
    output logic             ej_r,
    output logic             ej_l_vld,
    output logic             ej_r_vld
);

    assign ej_l = cur[WIDTH-1];
    assign ej_r = cur[0];

    always_comb begin
        nxt      = cur;
        ej_l_vld = 1'b0;
        ej_r_vld = 1'b0;
        case (mode)
            MODE_SHL: begin
                nxt      = {cur[WIDTH-2:0], sin_l};
                ej_l_vld = 1'b1;
            end
            MODE_SHR: begin
                nxt      = {sin_r, cur[WIDTH-1:1]};
                ej_r_vld = 1'b1;
            end
            MODE_ROL: begin
                nxt      = {cur[WIDTH-2:0], cur[WIDTH-1]};
                ej_l_vld = 1'b1;
            end
            MODE_ROR: begin
                nxt      = {cur[0], cur[WIDTH-1:1]};
                ej_r_vld = 1'b1;
            end
            MODE_ASR: begin
                nxt      = {cur[WIDTH-1], cur[WIDTH-1:1]};
                ej_r_vld = 1'b1;
            end
            MODE_LOAD: nxt = pdata;
            MODE_CLR:  nxt = '0;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operation and a counted autonomous burst.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNTW-1:0]  count,
    output logic [WIDTH-1:0] out,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_t            state;
    logic [2:0]        op_q;
    logic [CNTW-1:0]   rem_q;
    logic [2:0]        core_mode;
    logic [WIDTH-1:0]  nxt;
    logic              ej_l, ej_r, ej_l_vld, ej_r_vld;

    // During a burst the latched op drives the core; serial pins stay live.
    assign core_mode = (state == ST_RUN) ? op_q : mode;

    shift_core #(.WIDTH(WIDTH)) u_core (
        .cur      (out),
        .mode     (core_mode),
        .pdata    (pdata),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .nxt      (nxt),
        .ej_l     (ej_l),
        .ej_r     (ej_r),
        .ej_l_vld (ej_l_vld),
        .ej_r_vld (ej_r_vld)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            op_q   <= MODE_HOLD;
            rem_q  <= '0;
            out    <= '0;
            sout_l <= 1'b0;
            sout_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= mode;
                        // Non-shift modes and zero counts collapse to a bare done pulse.
                        if (is_shift(mode) && (count != '0)) begin
                            rem_q <= count;
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end else begin
                            rem_q <= '0;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end
                    end else begin
                        out <= nxt;
                        if (ej_l_vld) sout_l <= ej_l;
                        if (ej_r_vld) sout_r <= ej_r;
                    end
                end
                ST_RUN: begin
                    out   <= nxt;
                    rem_q <= rem_q - CNTW'(1);
                    if (ej_l_vld) sout_l <= ej_l;
                    if (ej_r_vld) sout_r <= ej_r;
                    if (rem_q == CNTW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNTW  = 4;

    logic             clk;
    logic             rstn;
    logic             en;
    logic [2:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] out;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .mode   (mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .pdata  (pdata),
        .start  (start),
        .count  (count),
        .out    (out),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        mode  = 3'd6;
        pdata = v;
        start = 1'b0;
        step();
        mode  = 3'd0;
    endtask

    task automatic test_reset();
        load(8'hFF);
        checks++; if (out !== 8'hFF) begin errors++; $display("FAIL rst_preload: out=%h want ff", out); end
        rstn  = 1'b0;
        start = 1'b1;
        mode  = 3'd1;
        count = 4'd3;
        step();
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL rst_out: out=%h want 00", out); end
        checks++; if ({busy, done, sout_l, sout_r} !== 4'b0000) begin
            errors++; $display("FAIL rst_flags: busy/done/sl/sr=%b want 0000", {busy, done, sout_l, sout_r}); end
        rstn  = 1'b1;
        start = 1'b0;
        mode  = 3'd0;
        step();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_idle: busy/done=%b want 00", {busy, done}); end
    endtask

    task automatic test_load_shift();
        load(8'hA5);
        checks++; if (out !== 8'hA5) begin errors++; $display("FAIL load: out=%h want a5", out); end
        mode = 3'd1; sin_l = 1'b1;
        step();
        checks++; if (out !== 8'h4B) begin errors++; $display("FAIL shl_out: out=%h want 4b", out); end
        checks++; if (sout_l !== 1'b1) begin errors++; $display("FAIL shl_sout_l: got %b want 1", sout_l); end
        mode = 3'd2; sin_r = 1'b0; sin_l = 1'b0;
        step();
        checks++; if (out !== 8'h25) begin errors++; $display("FAIL shr_out: out=%h want 25", out); end
        checks++; if (sout_r !== 1'b1) begin errors++; $display("FAIL shr_sout_r: got %b want 1", sout_r); end
        checks++; if (sout_l !== 1'b1) begin errors++; $display("FAIL shr_sout_l_hold: got %b want 1", sout_l); end
        mode = 3'd0;
        step();
        checks++; if (out !== 8'h25) begin errors++; $display("FAIL hold: out=%h want 25", out); end
    endtask

    task automatic test_asr();
        logic [WIDTH-1:0] exp_v [3];
        exp_v[0] = 8'hC0; exp_v[1] = 8'hE0; exp_v[2] = 8'hF0;
        load(8'h80);
        mode = 3'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out !== exp_v[i]) begin errors++; $display("FAIL asr_out[%0d]: out=%h want %h", i, out, exp_v[i]); end
            checks++; if (sout_r !== 1'b0) begin errors++; $display("FAIL asr_sout_r[%0d]: got %b want 0", i, sout_r); end
        end
        mode = 3'd0;
    endtask

    task automatic test_burst_rotate();
        logic [WIDTH-1:0] ror_v [4];
        logic [WIDTH-1:0] rol_v [8];
        ror_v[0] = 8'h09; ror_v[1] = 8'h84; ror_v[2] = 8'h42; ror_v[3] = 8'h21;
        rol_v[0] = 8'h24; rol_v[1] = 8'h48; rol_v[2] = 8'h90; rol_v[3] = 8'h21;
        rol_v[4] = 8'h42; rol_v[5] = 8'h84; rol_v[6] = 8'h09; rol_v[7] = 8'h12;

        load(8'h12);
        mode = 3'd4; start = 1'b1; count = 4'd4;
        step();
        checks++; if (out !== 8'h12 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ror_accept: out=%h busy=%b done=%b want 12 1 0", out, busy, done); end
        // Changed mode and start must be ignored while busy.
        mode = 3'd7; start = 1'b1; count = 4'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out !== ror_v[i]) begin errors++; $display("FAIL ror_out[%0d]: out=%h want %h", i, out, ror_v[i]); end
            checks++; if (busy !== (i < 3) || done !== (i == 3)) begin
                errors++; $display("FAIL ror_hs[%0d]: busy=%b done=%b want %b %b", i, busy, done, (i < 3), (i == 3)); end
        end
        checks++; if (sout_r !== 1'b0) begin errors++; $display("FAIL ror_sout_r: got %b want 0", sout_r); end
        start = 1'b0; mode = 3'd0;
        step();
        checks++; if ({busy, done} !== 2'b00 || out !== 8'h21) begin
            errors++; $display("FAIL ror_idle: busy/done=%b out=%h want 00 21", {busy, done}, out); end

        load(8'h12);
        mode = 3'd3; start = 1'b1; count = 4'd8;
        step();
        start = 1'b0; mode = 3'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (out !== rol_v[i]) begin errors++; $display("FAIL rol_out[%0d]: out=%h want %h", i, out, rol_v[i]); end
            checks++; if (busy !== (i < 7) || done !== (i == 7)) begin
                errors++; $display("FAIL rol_hs[%0d]: busy=%b done=%b want %b %b", i, busy, done, (i < 7), (i == 7)); end
        end
        step();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rol_idle: busy/done=%b want 00", {busy, done}); end
    endtask

    task automatic test_stall();
        load(8'h01);
        mode = 3'd1; sin_l = 1'b0; start = 1'b1; count = 4'd3;
        step();
        start = 1'b0; mode = 3'd0;
        step();
        checks++; if (out !== 8'h02 || busy !== 1'b1) begin errors++; $display("FAIL stall_first: out=%h busy=%b want 02 1", out, busy); end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (out !== 8'h02 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: out=%h busy=%b done=%b want 02 1 0", i, out, busy, done); end
        end
        en = 1'b1;
        step();
        checks++; if (out !== 8'h04 || busy !== 1'b1) begin errors++; $display("FAIL stall_second: out=%h busy=%b want 04 1", out, busy); end
        step();
        checks++; if (out !== 8'h08 || busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL stall_final: out=%h busy=%b done=%b want 08 0 1", out, busy, done); end
        en = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done_hold: done=%b want 1", done); end
        en = 1'b1;
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_clear: done=%b want 0", done); end
    endtask

    task automatic test_zero_count();
        load(8'h5A);
        mode = 3'd1; start = 1'b1; count = 4'd0;
        step();
        checks++; if (out !== 8'h5A || busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL zc_accept: out=%h busy=%b done=%b want 5a 0 1", out, busy, done); end
        // A start arriving in FIN must not launch a burst.
        count = 4'd2;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h5A) begin
            errors++; $display("FAIL zc_fin: out=%h busy=%b done=%b want 5a 0 0", out, busy, done); end
        start = 1'b0; mode = 3'd0;
        step();
        checks++; if (busy !== 1'b0 || out !== 8'h5A) begin errors++; $display("FAIL fin_start_ignored: out=%h busy=%b want 5a 0", out, busy); end

        mode = 3'd6; pdata = 8'hFF; start = 1'b1; count = 4'd3;
        step();
        checks++; if (out !== 8'h5A || busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL ld_start: out=%h busy=%b done=%b want 5a 0 1", out, busy, done); end
        start = 1'b0; mode = 3'd0;
        step();
        checks++; if (out !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ld_start_end: out=%h busy=%b done=%b want 5a 0 0", out, busy, done); end
    endtask

    task automatic test_reset_abort();
        load(8'h33);
        mode = 3'd1; sin_l = 1'b1; start = 1'b1; count = 4'd5;
        step();
        start = 1'b0; mode = 3'd0;
        step();
        step();
        checks++; if (out !== 8'hCF || busy !== 1'b1) begin errors++; $display("FAIL abort_pre: out=%h busy=%b want cf 1", out, busy); end
        rstn = 1'b0;
        step();
        checks++; if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_rst: out=%h busy=%b done=%b want 00 0 0", out, busy, done); end
        rstn = 1'b1; sin_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00) begin
                errors++; $display("FAIL abort_after[%0d]: out=%h busy=%b done=%b want 00 0 0", i, out, busy, done); end
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; mode = 3'd0; sin_l = 1'b0; sin_r = 1'b0;
        pdata = '0; start = 1'b0; count = '0;
        step();
        step();
        rstn = 1'b1;
        test_reset();
        test_load_shift();
        test_asr();
        test_burst_rotate();
        test_stall();
        test_zero_count();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
